// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state codes, key codes and player HP state enum
package game_pkg;

    localparam logic [1:0] GS_PRE  = 2'b00;
    localparam logic [1:0] GS_IN   = 2'b01;
    localparam logic [1:0] GS_POST = 2'b10;

    localparam logic [7:0] KEY_START   = 8'h28;
    localparam logic [7:0] KEY_RESTART = 8'h15;
    localparam logic [7:0] KEY_MENU    = 8'h29;

    typedef enum logic [1:0] {
        HP_ALIVE  = 2'b00,
        HP_INVULN = 2'b01,
        HP_DYING  = 2'b10,
        HP_DEAD   = 2'b11
    } hp_state_e;

    // Heal by one, never above the configured maximum.
    function automatic logic [3:0] hp_inc_sat(input logic [3:0] hp, input logic [3:0] hp_max);
        return (hp >= hp_max) ? hp_max : hp + 4'd1;
    endfunction

endpackage

// File: rtl/key_edge_pulse.sv
// rtl/key_edge_pulse.sv - one registered pulse on the first sample of a gated keycode
module key_edge_pulse #(
    parameter logic [7:0] KEY = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       pulse
);

    logic [7:0] prev_key_q, prev_key_d;
    logic       pulse_q, pulse_d;

    // Fire only on the transition into KEY; a held key stays quiet, a disabled edge is dropped.
    always_comb begin
        prev_key_d = keycode;
        pulse_d    = enable && (keycode == KEY) && (prev_key_q != KEY);
    end

    // Previous-key and pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_key_q <= 8'h00;
            pulse_q    <= 1'b0;
        end else begin
            prev_key_q <= prev_key_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/player_event_gen.sv
// rtl/player_event_gen.sv - key events, player HP/invulnerability/death timing and scoring
module player_event_gen
    import game_pkg::*;
#(
    parameter logic [3:0] HP_MAX        = 4'd5,
    parameter int          INVULN_FRAMES = 60,
    parameter int          DEATH_FRAMES  = 90,
    parameter int          SCORE_W       = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [7:0]         keycode,
    input  logic [1:0]         game_state,
    input  logic               game_reset,
    input  logic               score_reset,
    input  logic               hit,
    input  logic               heal,
    input  logic               score_inc,
    output logic               game_start,
    output logic               game_restart,
    output logic               game_menu,
    output logic               game_exit,
    output logic [3:0]         hp,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score,
    output logic               invuln
);

    localparam int MAX_FRAMES = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0]   INVULN_CNT = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0]   DEATH_CNT  = CNT_W'(DEATH_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    key_edge_pulse #(.KEY(KEY_START)) u_key_start (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .enable(game_state == GS_PRE), .pulse(game_start)
    );
    key_edge_pulse #(.KEY(KEY_RESTART)) u_key_restart (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .enable(game_state == GS_POST), .pulse(game_restart)
    );
    key_edge_pulse #(.KEY(KEY_MENU)) u_key_menu (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .enable(game_state == GS_POST), .pulse(game_menu)
    );

    hp_state_e          state_q, state_d;
    logic [3:0]         hp_q, hp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               exit_q, exit_d;
    logic               invuln_q, invuln_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;

    // HP state machine, frame counter, score and best-score next values.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        best_d  = best_q;

        if (game_reset) begin
            state_d = HP_ALIVE;
            hp_d    = HP_MAX;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HP_ALIVE: begin
                    // A simultaneous heal is discarded when a hit lands.
                    if (hit) begin
                        if (hp_q > 4'd1) begin
                            hp_d    = hp_q - 4'd1;
                            cnt_d   = INVULN_CNT;
                            state_d = HP_INVULN;
                        end else begin
                            hp_d    = 4'd0;
                            cnt_d   = DEATH_CNT;
                            state_d = HP_DYING;
                        end
                    end else if (heal) begin
                        hp_d = hp_inc_sat(hp_q, HP_MAX);
                    end
                end
                HP_INVULN: begin
                    if (heal) begin
                        hp_d = hp_inc_sat(hp_q, HP_MAX);
                    end
                    if (frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = HP_ALIVE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                HP_DYING: begin
                    if (frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = HP_DEAD;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (score_reset) begin
            score_d = '0;
        end else if (score_inc && (state_q == HP_ALIVE || state_q == HP_INVULN)
                     && (score_q != SCORE_MAX)) begin
            score_d = score_q + SCORE_W'(1);
        end

        // Capture the finished run's score on the cycle the player enters DEAD.
        if (state_d == HP_DEAD && state_q != HP_DEAD && score_q > best_q) begin
            best_d = score_q;
        end

        exit_d   = (state_d == HP_DEAD);
        invuln_d = (state_d == HP_INVULN);
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= HP_ALIVE;
            hp_q     <= HP_MAX;
            cnt_q    <= '0;
            exit_q   <= 1'b0;
            invuln_q <= 1'b0;
            score_q  <= '0;
            best_q   <= '0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            exit_q   <= exit_d;
            invuln_q <= invuln_d;
            score_q  <= score_d;
            best_q   <= best_d;
        end
    end

    assign game_exit  = exit_q;
    assign hp         = hp_q;
    assign score      = score_q;
    assign best_score = best_q;
    assign invuln     = invuln_q;

endmodule
